// File: rtl/mem_serdes_pkg.sv
// Shared widths and TX state type for the backup-memory serializer.
// Derived constants reflect the default link configuration.
package mem_serdes_pkg;

    localparam int DEF_HTIF_WIDTH    = 16;
    localparam int DEF_MEM_ADDR_BITS = 26;
    localparam int DEF_MEM_TAG_BITS  = 5;
    localparam int DEF_MEM_DATA_BITS = 128;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int CMD_BITS       = DEF_MEM_ADDR_BITS + DEF_MEM_TAG_BITS + 1;
    localparam int CMD_BEATS      = cdiv(CMD_BITS, DEF_HTIF_WIDTH);
    localparam int DATA_BEATS     = DEF_MEM_DATA_BITS / DEF_HTIF_WIDTH;
    localparam int RESP_BITS      = DEF_MEM_DATA_BITS + DEF_MEM_TAG_BITS;
    localparam int RESP_BEATS     = cdiv(RESP_BITS, DEF_HTIF_WIDTH);
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {IDLE, CMD, DATA} tx_state_e;

endpackage

// File: rtl/mem_serdes_if.sv
// Wide memory request/response plus narrow HTIF beat signals of the serializer.
// slave = serializer view, master = memory port / pins view.
interface mem_serdes_if
    import mem_serdes_pkg::*;
#(
    parameter int HTIF_WIDTH    = DEF_HTIF_WIDTH,
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
    parameter int MEM_TAG_BITS  = DEF_MEM_TAG_BITS,
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS
);
    logic                     wide_req_cmd_valid;
    logic                     wide_req_cmd_ready;
    logic                     wide_req_cmd_rw;
    logic [MEM_ADDR_BITS-1:0] wide_req_cmd_addr;
    logic [MEM_TAG_BITS-1:0]  wide_req_cmd_tag;
    logic                     wide_req_data_valid;
    logic                     wide_req_data_ready;
    logic [MEM_DATA_BITS-1:0] wide_req_data_bits;
    logic                     wide_resp_valid;
    logic [MEM_TAG_BITS-1:0]  wide_resp_tag;
    logic [MEM_DATA_BITS-1:0] wide_resp_data;
    logic                     narrow_req_valid;
    logic                     narrow_req_ready;
    logic [HTIF_WIDTH-1:0]    narrow_req_bits;
    logic                     narrow_resp_valid;
    logic [HTIF_WIDTH-1:0]    narrow_resp_bits;
    logic                     err_unexpected_resp;

    modport slave (
        input  wide_req_cmd_valid, wide_req_cmd_rw, wide_req_cmd_addr, wide_req_cmd_tag,
        input  wide_req_data_valid, wide_req_data_bits,
        input  narrow_req_ready, narrow_resp_valid, narrow_resp_bits,
        output wide_req_cmd_ready, wide_req_data_ready,
        output wide_resp_valid, wide_resp_tag, wide_resp_data,
        output narrow_req_valid, narrow_req_bits, err_unexpected_resp
    );

    modport master (
        output wide_req_cmd_valid, wide_req_cmd_rw, wide_req_cmd_addr, wide_req_cmd_tag,
        output wide_req_data_valid, wide_req_data_bits,
        output narrow_req_ready, narrow_resp_valid, narrow_resp_bits,
        input  wide_req_cmd_ready, wide_req_data_ready,
        input  wide_resp_valid, wide_resp_tag, wide_resp_data,
        input  narrow_req_valid, narrow_req_bits, err_unexpected_resp
    );

endinterface

// File: rtl/mem_serdes_rx.sv
// RX half of the serializer: gathers narrow response beats into a frame and
// emits one registered wide response pulse per complete frame.
module mem_serdes_rx
    import mem_serdes_pkg::*;
#(
    parameter int HTIF_WIDTH    = DEF_HTIF_WIDTH,
    parameter int MEM_TAG_BITS  = DEF_MEM_TAG_BITS,
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS
) (
    input  logic                     htif_clk,
    input  logic                     reset,
    input  logic                     beat_valid_i,
    input  logic [HTIF_WIDTH-1:0]    beat_bits_i,
    output logic                     resp_valid_o,
    output logic [MEM_TAG_BITS-1:0]  resp_tag_o,
    output logic [MEM_DATA_BITS-1:0] resp_data_o
);
    localparam int RESP_W  = MEM_DATA_BITS + MEM_TAG_BITS;
    localparam int RESP_N  = cdiv(RESP_W, HTIF_WIDTH);
    localparam int FRAME_W = RESP_N * HTIF_WIDTH;
    localparam int CNT_W   = $clog2(RESP_N + 1);

    // Only the earlier beats are stored; the current beat completes the frame.
    logic [FRAME_W-HTIF_WIDTH-1:0] frame_q;
    logic [FRAME_W-1:0]            frame_d;
    logic [CNT_W-1:0]              cnt_q;
    logic                          vld_q;
    logic [MEM_TAG_BITS-1:0]       tag_q;
    logic [MEM_DATA_BITS-1:0]      data_q;

    assign frame_d = {beat_bits_i, frame_q};

    always_ff @(posedge htif_clk) begin
        if (reset) begin
            frame_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            vld_q <= 1'b0;
            if (beat_valid_i) begin
                frame_q <= frame_d[FRAME_W-1:HTIF_WIDTH];
                if (cnt_q == CNT_W'(RESP_N - 1)) begin
                    cnt_q  <= '0;
                    vld_q  <= 1'b1;
                    tag_q  <= frame_d[MEM_TAG_BITS-1:0];
                    data_q <= frame_d[RESP_W-1:MEM_TAG_BITS];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign resp_valid_o = vld_q;
    assign resp_tag_o   = tag_q;
    assign resp_data_o  = data_q;

endmodule

// File: rtl/mem_serdes.sv
// Chip-side backup-memory serializer: wide cmd/data -> narrow beats (TX FSM),
// narrow beats -> wide response (mem_serdes_rx). MEM_SERDES_CHECK_EN adds an
// outstanding-read checker driving err_unexpected_resp.
module mem_serdes
    import mem_serdes_pkg::*;
#(
    parameter int HTIF_WIDTH    = DEF_HTIF_WIDTH,
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
    parameter int MEM_TAG_BITS  = DEF_MEM_TAG_BITS,
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS
) (
    input logic          htif_clk,
    input logic          reset,
    mem_serdes_if.slave  io
);
    localparam int CMD_W  = MEM_ADDR_BITS + MEM_TAG_BITS + 1;
    localparam int CMD_N  = cdiv(CMD_W, HTIF_WIDTH);
    localparam int DATA_N = MEM_DATA_BITS / HTIF_WIDTH;
    localparam int CMD_SW = CMD_N * HTIF_WIDTH;
    localparam int SH_W   = (CMD_SW > MEM_DATA_BITS) ? CMD_SW : MEM_DATA_BITS;
    localparam int BCNT_W = $clog2(((CMD_N > DATA_N) ? CMD_N : DATA_N) + 1);

    tx_state_e         state_q;
    logic [SH_W-1:0]   shreg_q;
    logic [BCNT_W-1:0] beat_cnt_q;
    logic [1:0]        word_cnt_q;
    logic              loaded_q;
    logic              rw_q;
    logic              nvalid_q;
    logic              cmd_rdy_q;
    logic              data_rdy_q;

    logic cmd_fire, data_fire, beat_fire;

    // Readies are masked by reset so they read 0 for the whole reset window.
    assign io.wide_req_cmd_ready  = cmd_rdy_q & ~reset;
    assign io.wide_req_data_ready = data_rdy_q & ~reset;
    assign io.narrow_req_valid    = nvalid_q;
    assign io.narrow_req_bits     = shreg_q[HTIF_WIDTH-1:0];

    assign cmd_fire  = io.wide_req_cmd_valid & io.wide_req_cmd_ready;
    assign data_fire = io.wide_req_data_valid & io.wide_req_data_ready;
    assign beat_fire = nvalid_q & io.narrow_req_ready;

    always_ff @(posedge htif_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            loaded_q   <= 1'b0;
            rw_q       <= 1'b0;
            nvalid_q   <= 1'b0;
            cmd_rdy_q  <= 1'b1;
            data_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_fire) begin
                    shreg_q    <= SH_W'({io.wide_req_cmd_addr, io.wide_req_cmd_tag, io.wide_req_cmd_rw});
                    rw_q       <= io.wide_req_cmd_rw;
                    beat_cnt_q <= '0;
                    nvalid_q   <= 1'b1;
                    cmd_rdy_q  <= 1'b0;
                    state_q    <= CMD;
                end
                CMD: if (beat_fire) begin
                    shreg_q <= shreg_q >> HTIF_WIDTH;
                    if (beat_cnt_q == BCNT_W'(CMD_N - 1)) begin
                        beat_cnt_q <= '0;
                        nvalid_q   <= 1'b0;
                        if (rw_q) begin
                            data_rdy_q <= 1'b1;
                            state_q    <= DATA;
                        end else begin
                            cmd_rdy_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BCNT_W'(1);
                    end
                end
                DATA: if (!loaded_q) begin
                    if (data_fire) begin
                        shreg_q    <= SH_W'(io.wide_req_data_bits);
                        loaded_q   <= 1'b1;
                        data_rdy_q <= 1'b0;
                        nvalid_q   <= 1'b1;
                    end
                end else if (beat_fire) begin
                    shreg_q <= shreg_q >> HTIF_WIDTH;
                    if (beat_cnt_q == BCNT_W'(DATA_N - 1)) begin
                        beat_cnt_q <= '0;
                        loaded_q   <= 1'b0;
                        nvalid_q   <= 1'b0;
                        if (word_cnt_q == 2'(WORDS_PER_LINE - 1)) begin
                            word_cnt_q <= '0;
                            cmd_rdy_q  <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            word_cnt_q <= word_cnt_q + 2'd1;
                            data_rdy_q <= 1'b1;
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BCNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_serdes_rx #(
        .HTIF_WIDTH    (HTIF_WIDTH),
        .MEM_TAG_BITS  (MEM_TAG_BITS),
        .MEM_DATA_BITS (MEM_DATA_BITS)
    ) u_rx (
        .htif_clk     (htif_clk),
        .reset        (reset),
        .beat_valid_i (io.narrow_resp_valid),
        .beat_bits_i  (io.narrow_resp_bits),
        .resp_valid_o (io.wide_resp_valid),
        .resp_tag_o   (io.wide_resp_tag),
        .resp_data_o  (io.wide_resp_data)
    );

`ifdef MEM_SERDES_CHECK_EN
    // Each read owes WORDS_PER_LINE responses; a response with nothing owed is an error.
    logic [3:0] outst_q, outst_d;
    logic [4:0] outst_sum;
    logic       err_q, rd_fire;

    assign rd_fire = cmd_fire & ~io.wide_req_cmd_rw;

    always_comb begin
        outst_sum = {1'b0, outst_q};
        if (rd_fire) outst_sum = outst_sum + 5'd4;
        if (io.wide_resp_valid && outst_q != 4'd0) outst_sum = outst_sum - 5'd1;
        outst_d = (outst_sum > 5'd15) ? 4'd15 : outst_sum[3:0];
    end

    always_ff @(posedge htif_clk) begin
        if (reset) begin
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if ((io.wide_resp_valid && outst_q == 4'd0) || (rd_fire && outst_q > 4'd11))
                err_q <= 1'b1;
        end
    end

    assign io.err_unexpected_resp = err_q;
`else
    assign io.err_unexpected_resp = 1'b0;
`endif

endmodule
